// File: rtl/pkt_tx_scheduler_pkg.sv
// Shared parameters and helpers for the packet transmit scheduler.
package pkt_tx_scheduler_pkg;

  localparam int BYTE_LEN           = 8;
  localparam int PACKET_BUFFER_SIZE = 2048;

  typedef logic [BYTE_LEN-1:0] byte_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_tx_scheduler_desc_fifo.sv
// Synchronous descriptor FIFO; a push while full is refused even if a pop
// happens in the same cycle.
module desc_fifo
  import pkt_tx_scheduler_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4,
  localparam int PW   = clog2(DEPTH),
  localparam int CW   = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/pkt_tx_scheduler.sv
// Packet transmit scheduler: queues byte-range descriptors and launches them
// to the memory streamer. Define PKT_TX_SCHEDULER_IFG_EN to add an inter-frame gap.
module pkt_tx_scheduler
  import pkt_tx_scheduler_pkg::*;
#(
  parameter int RAM_SIZE   = PACKET_BUFFER_SIZE,
  parameter int DESC_DEPTH = 4,
  parameter int IFG_CYCLES = 48,
  localparam int AW        = clog2(RAM_SIZE),
  localparam int CW        = clog2(DESC_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          desc_we,
  input  logic [AW-1:0] desc_start,
  input  logic [AW-1:0] desc_end,
  output logic          desc_full,
  output logic [CW-1:0] desc_count,
  output logic          desc_drop,
  input  logic          tx_enable,
  output logic          stream_start,
  output logic [AW-1:0] stream_read_start,
  output logic [AW-1:0] stream_read_end,
  input  logic          stream_outclk,
  output logic          pkt_done,
  output logic          busy
);

`ifdef PKT_TX_SCHEDULER_IFG_EN
  localparam int GW = clog2(IFG_CYCLES + 1);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1, ST_GAP = 2'd2} state_t;
  logic [GW-1:0] gap_q;
`else
  typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;
`endif

  state_t          state_q;
  logic [AW-1:0]   rem_q;
  logic [AW-1:0]   rd_start_q;
  logic [AW-1:0]   rd_end_q;
  logic            stream_start_q;
  logic            pkt_done_q;
  logic            drop_q;
  logic [2*AW-1:0] head;
  logic [AW-1:0]   head_start;
  logic [AW-1:0]   head_end;
  logic [AW-1:0]   push_len;
  logic            push_req;
  logic            launch;

  // Lengths wrap modulo the buffer size, so a range may cross address zero.
  assign push_len   = desc_end - desc_start;
  assign push_req   = desc_we && !desc_full && (push_len != '0);
  assign launch     = (state_q == ST_IDLE) && tx_enable && (desc_count != '0);
  assign head_start = head[2*AW-1:AW];
  assign head_end   = head[AW-1:0];

  desc_fifo #(.WIDTH(2 * AW), .DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .pop_i   (launch),
    .data_i  ({desc_start, desc_end}),
    .data_o  (head),
    .full_o  (desc_full),
    .count_o (desc_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rem_q          <= '0;
      rd_start_q     <= '0;
      rd_end_q       <= '0;
      stream_start_q <= 1'b0;
      pkt_done_q     <= 1'b0;
      drop_q         <= 1'b0;
`ifdef PKT_TX_SCHEDULER_IFG_EN
      gap_q          <= '0;
`endif
    end else begin
      stream_start_q <= 1'b0;
      pkt_done_q     <= 1'b0;
      drop_q         <= desc_we && !push_req;
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            state_q        <= ST_STREAM;
            stream_start_q <= 1'b1;
            rd_start_q     <= head_start;
            rd_end_q       <= head_end;
            rem_q          <= head_end - head_start;
          end
        end
        ST_STREAM: begin
          if (stream_outclk) begin
            rem_q <= rem_q - AW'(1);
            if (rem_q == AW'(1)) begin
              pkt_done_q <= 1'b1;
`ifdef PKT_TX_SCHEDULER_IFG_EN
              state_q    <= ST_GAP;
              gap_q      <= GW'(IFG_CYCLES);
`else
              state_q    <= ST_IDLE;
`endif
            end
          end
        end
`ifdef PKT_TX_SCHEDULER_IFG_EN
        ST_GAP: begin
          gap_q <= gap_q - GW'(1);
          if (gap_q == GW'(1)) state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stream_start      = stream_start_q;
  assign stream_read_start = rd_start_q;
  assign stream_read_end   = rd_end_q;
  assign pkt_done          = pkt_done_q;
  assign desc_drop         = drop_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pkt_tx_scheduler.sv
// Lockstep bench: directed scenarios plus random traffic, every output compared
// each cycle against a queue-based transaction model.
module tb_pkt_tx_scheduler;

  localparam int RAM   = 2048;
  localparam int DEPTH = 4;
  localparam int IFG   = 6;
  localparam int AW    = 11;
  localparam int CW    = 3;
`ifdef PKT_TX_SCHEDULER_IFG_EN
  localparam bit IFG_ON = 1'b1;
`else
  localparam bit IFG_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          desc_we = 1'b0;
  logic [AW-1:0] desc_start = '0;
  logic [AW-1:0] desc_end = '0;
  logic          desc_full;
  logic [CW-1:0] desc_count;
  logic          desc_drop;
  logic          tx_enable = 1'b0;
  logic          stream_start;
  logic [AW-1:0] stream_read_start;
  logic [AW-1:0] stream_read_end;
  logic          stream_outclk = 1'b0;
  logic          pkt_done;
  logic          busy;

  pkt_tx_scheduler #(.RAM_SIZE(RAM), .DESC_DEPTH(DEPTH), .IFG_CYCLES(IFG)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .desc_we           (desc_we),
    .desc_start        (desc_start),
    .desc_end          (desc_end),
    .desc_full         (desc_full),
    .desc_count        (desc_count),
    .desc_drop         (desc_drop),
    .tx_enable         (tx_enable),
    .stream_start      (stream_start),
    .stream_read_start (stream_read_start),
    .stream_read_end   (stream_read_end),
    .stream_outclk     (stream_outclk),
    .pkt_done          (pkt_done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;
  bit prev_busy = 1'b1;

  // Reference model: a descriptor queue plus "what the transmitter is doing now".
  int q_s[$];
  int q_e[$];
  int phase     = 0;   // 0 idle, 1 streaming, 2 gap
  int bytes_left = 0;
  int gap_left  = 0;
  int m_rs = 0, m_re = 0;
  bit m_start = 0, m_done = 0, m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int range_len(input int s, input int e);
    return (e - s + RAM) % RAM;
  endfunction

  task automatic model_step(input bit we, input int s, input int e,
                            input bit txe, input bit oc, input bit rn);
    bit accept;
    if (!rn) begin
      q_s.delete(); q_e.delete();
      phase = 0; bytes_left = 0; gap_left = 0;
      m_rs = 0; m_re = 0; m_start = 0; m_done = 0; m_drop = 0;
      return;
    end
    accept  = we && (q_s.size() < DEPTH) && (range_len(s, e) != 0);
    m_drop  = we && !accept;
    m_start = 0;
    m_done  = 0;
    if (phase == 0) begin
      if (txe && q_s.size() > 0) begin
        m_rs = q_s.pop_front();
        m_re = q_e.pop_front();
        bytes_left = range_len(m_rs, m_re);
        m_start = 1;
        phase = 1;
      end
    end else if (phase == 1) begin
      if (oc) begin
        bytes_left--;
        if (bytes_left == 0) begin
          m_done = 1;
          gap_left = IFG;
          phase = IFG_ON ? 2 : 0;
        end
      end
    end else begin
      gap_left--;
      if (gap_left == 0) phase = 0;
    end
    if (accept) begin
      q_s.push_back(s);
      q_e.push_back(e);
    end
  endtask

  task automatic check_outputs();
    chk("busy",         busy,              phase != 0);
    chk("desc_count",   desc_count,        q_s.size());
    chk("desc_full",    desc_full,         q_s.size() == DEPTH);
    chk("desc_drop",    desc_drop,         m_drop);
    chk("stream_start", stream_start,      m_start);
    chk("pkt_done",     pkt_done,          m_done);
    chk("read_start",   stream_read_start, m_rs);
    chk("read_end",     stream_read_end,   m_re);
    if (stream_start) chk("idle_before_launch", prev_busy, 0);
    prev_busy = busy;
  endtask

  task automatic cycle(input bit we, input int s, input int e,
                       input bit txe, input bit oc, input bit rn);
    @(negedge clk);
    if (chk_en) check_outputs();
    desc_we       = we;
    desc_start    = AW'(s);
    desc_end      = AW'(e);
    tx_enable     = txe;
    stream_outclk = oc;
    rst_n         = rn;
    @(posedge clk);
    model_step(we, s, e, txe, oc, rn);
  endtask

  task automatic idle(input int n, input bit txe, input bit oc);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, txe, oc, 1);
  endtask

  initial begin
    int s, len;
    cycle(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);
    idle(2, 0, 0);

    // Basic launch of a 4-byte packet.
    cycle(1, 16, 20, 1, 0, 1);
    idle(3, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 1, 1);
      cycle(0, 0, 0, 1, 0, 1);
    end
    idle(IFG + 3, 1, 0);

    // Range wrapping past the end of the buffer.
    cycle(1, 2044, 4, 1, 0, 1);
    idle(2, 1, 0);
    idle(8, 1, 1);
    idle(IFG + 3, 1, 0);

    // Fill the queue, overflow it, and push a zero-length range.
    for (int i = 0; i < 5; i++) cycle(1, 40 * i, 40 * i + 3, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 7, 7, 0, 0, 1);
    idle(2, 0, 0);
    idle(60, 1, 1);

    // tx_enable dropped mid-packet: A finishes, B waits.
    cycle(1, 100, 103, 0, 0, 1);
    cycle(1, 200, 202, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    idle(2, 0, 0);
    idle(3, 0, 1);
    idle(IFG + 10, 0, 0);
    idle(20, 1, 1);

    // Reset after 2 of 10 bytes, with more descriptors queued.
    cycle(1, 300, 310, 0, 0, 1);
    cycle(1, 400, 405, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    idle(1, 0, 0);
    idle(2, 0, 1);
    cycle(0, 0, 0, 1, 1, 0);
    idle(3, 1, 1);

    // Push every cycle while draining.
    for (int i = 0; i < 40; i++) cycle(1, 500 + i, 502 + i, 1, 1, 1);
    idle(40, 1, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      s   = $urandom_range(0, RAM - 1);
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      cycle($urandom_range(0, 2) == 0, s, (s + len) % RAM,
            $urandom_range(0, 4) != 0, $urandom_range(0, 1),
            $urandom_range(0, 299) != 0);
    end
    idle(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
